// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I datapath types for the data-memory path
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5} load_t;

  // Encoding 2'b11 is deliberately unassigned and is treated as an illegal store.
  typedef enum logic [1:0] {SB = 2'd0, SH = 2'd1, SW = 2'd2} store_t;

  typedef struct packed {
    word_t      addr;
    word_t      data;
    logic [3:0] byte_en;
  } sbuf_entry_t;

endpackage

// File: rtl/store_formatter.sv
// rtl/store_formatter.sv - combinational store lane formatting and alignment check
module store_formatter
  import rv32i_types_pkg::*;
(
  input  store_t      st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] word_addr,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misaligned
);

  assign word_addr = {st_addr[31:2], 2'b00};

  always_comb begin
    byte_en    = 4'b0000;
    wdata      = 32'h0;
    misaligned = 1'b0;
    case (st_type)
      SB: begin
        byte_en = 4'b0001 << st_addr[1:0];
        wdata   = {4{st_data[7:0]}};
      end
      SH: begin
        byte_en    = 4'b0011 << st_addr[1:0];
        wdata      = {2{st_data[15:0]}};
        misaligned = st_addr[0];
      end
      SW: begin
        byte_en    = 4'b1111;
        wdata      = st_data;
        misaligned = |st_addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - store FIFO between the core and data memory with load-overlap detection
module dmem_store_buffer
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        st_valid,
  output logic        st_ready,
  input  store_t      st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_fault,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        empty,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_busy
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  sbuf_entry_t      entries [DEPTH];
  logic [DEPTH-1:0] valid;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;

  logic [31:0] fmt_addr;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_byte_en;
  logic        fmt_misaligned;
  logic        full;
  logic        accept;
  logic        pop;
  sbuf_entry_t head;

  store_formatter u_formatter (
    .st_type    (st_type),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .word_addr  (fmt_addr),
    .byte_en    (fmt_byte_en),
    .wdata      (fmt_wdata),
    .misaligned (fmt_misaligned)
  );

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign st_ready = !full;
  assign st_fault = st_valid & fmt_misaligned;
  assign accept   = st_valid & st_ready & !fmt_misaligned;

  assign head        = entries[rd_ptr[PW-1:0]];
  assign mem_wen     = valid[rd_ptr[PW-1:0]];
  assign mem_addr    = mem_wen ? head.addr    : 32'h0;
  assign mem_wdata   = mem_wen ? head.data    : 32'h0;
  assign mem_byte_en = mem_wen ? head.byte_en : 4'h0;
  assign pop         = mem_wen & !mem_busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      // Accept needs a free slot and pop needs a valid head, so they never share an index.
      if (accept) begin
        entries[wr_ptr[PW-1:0]] <= '{addr: fmt_addr, data: fmt_wdata, byte_en: fmt_byte_en};
        valid[wr_ptr[PW-1:0]]   <= 1'b1;
        wr_ptr                  <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        valid[rd_ptr[PW-1:0]] <= 1'b0;
        rd_ptr                <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Word match ignores the byte offset of the load address.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (((entries[i].addr ^ ld_addr) & 32'hFFFF_FFFC) == 32'h0)) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
  import rv32i_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  store_t      st_type = SW;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_fault;
  logic [31:0] ld_addr = 32'hFFFF_FFF0;
  logic        ld_hazard;
  logic        empty;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  dmem_store_buffer #(.DEPTH(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_type     (st_type),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_fault    (st_fault),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .empty       (empty),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byte_en (mem_byte_en),
    .mem_busy    (mem_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_fault;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [11];

  task automatic send(input logic [1:0] typ, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_type  = store_t'(typ);
    st_addr  = addr;
    st_data  = data;
  endtask

  initial begin
    int wen_seen;

    vecs[0]  = '{1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
    vecs[1]  = '{1'b1, 2'd0, 32'h0000_1000, 32'h1234_5677, 1'b0, 1'b1, 32'h0000_1000, 32'h7777_7777, 4'b0001};
    vecs[2]  = '{1'b1, 2'd0, 32'h0000_1001, 32'hFFFF_FF3C, 1'b0, 1'b1, 32'h0000_1000, 32'h3C3C_3C3C, 4'b0010};
    vecs[3]  = '{1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_2000, 32'hCAFE_0102, 1'b0, 1'b1, 32'h0000_2000, 32'h0102_0102, 4'b0011};
    vecs[5]  = '{1'b1, 2'd1, 32'h0000_2003, 32'h1111_2222, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_2001, 32'h3333_4444, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[7]  = '{1'b1, 2'd2, 32'h0000_4008, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_4008, 32'hDEAD_BEEF, 4'b1111};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_400A, 32'h5555_6666, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[9]  = '{1'b1, 2'd3, 32'h0000_5000, 32'h7777_8888, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000};
    vecs[10] = '{1'b0, 2'd2, 32'h0000_2001, 32'h9999_AAAA, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};

    #2;
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", {28'b0, mem_byte_en}, 32'h0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_ready", {31'b0, st_ready}, 32'd1);
    check("rst_hazard", {31'b0, ld_hazard}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      st_valid = vecs[i].vld;
      st_type  = store_t'(vecs[i].typ);
      st_addr  = vecs[i].addr;
      st_data  = vecs[i].data;
      #1;
      check($sformatf("v%0d_fault", i), {31'b0, st_fault}, {31'b0, vecs[i].exp_fault});
      check($sformatf("v%0d_ready", i), {31'b0, st_ready}, 32'd1);
      @(negedge CLK);
      st_valid = 1'b0;
      #1;
      check($sformatf("v%0d_wen", i), {31'b0, mem_wen}, {31'b0, vecs[i].exp_wen});
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_be", i), {28'b0, mem_byte_en}, {28'b0, vecs[i].exp_be});
      check($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, !vecs[i].exp_wen});
      @(negedge CLK);
      #1;
      check($sformatf("v%0d_drained", i), {30'b0, empty, mem_wen}, 32'd2);
    end

    // Fill with memory stalled, then release for one cycle.
    @(negedge CLK);
    mem_busy = 1'b1;
    send(2'd2, 32'h100, 32'h1111_1111);
    @(negedge CLK);
    send(2'd2, 32'h104, 32'h2222_2222);
    #1;
    check("fill_first_wen", {31'b0, mem_wen}, 32'd1);
    check("fill_first_addr", mem_addr, 32'h100);
    @(negedge CLK);
    send(2'd2, 32'h108, 32'h3333_3333);
    #1;
    check("fill_full_ready", {31'b0, st_ready}, 32'd0);
    check("fill_full_empty", {31'b0, empty}, 32'd0);
    @(negedge CLK);
    #1;
    check("busy_hold_addr", mem_addr, 32'h100);
    check("busy_hold_wdata", mem_wdata, 32'h1111_1111);
    check("busy_hold_ready", {31'b0, st_ready}, 32'd0);
    mem_busy = 1'b0;
    @(negedge CLK);
    #1;
    check("release_ready", {31'b0, st_ready}, 32'd1);
    check("order_second_addr", mem_addr, 32'h104);
    mem_busy = 1'b1;
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    check("refill_ready", {31'b0, st_ready}, 32'd0);
    check("refill_head", mem_addr, 32'h104);
    mem_busy = 1'b0;
    @(negedge CLK);
    #1;
    check("order_third_addr", mem_addr, 32'h108);
    check("order_third_wdata", mem_wdata, 32'h3333_3333);
    @(negedge CLK);
    #1;
    check("fill_drained", {30'b0, empty, mem_wen}, 32'd2);

    // Back-to-back stores with concurrent drain.
    @(negedge CLK);
    send(2'd2, 32'h600, 32'hAAAA_0001);
    @(negedge CLK);
    send(2'd2, 32'h604, 32'hAAAA_0002);
    #1;
    check("b2b_first", mem_addr, 32'h600);
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    check("b2b_second", mem_addr, 32'h604);
    check("b2b_ready", {31'b0, st_ready}, 32'd1);
    @(negedge CLK);
    #1;
    check("b2b_drained", {31'b0, empty}, 32'd1);

    // Load-overlap detection against a stalled store.
    @(negedge CLK);
    mem_busy = 1'b1;
    ld_addr  = 32'h302;
    #1;
    check("hazard_none_empty", {31'b0, ld_hazard}, 32'd0);
    send(2'd2, 32'h300, 32'h0BAD_F00D);
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    check("hazard_same_word", {31'b0, ld_hazard}, 32'd1);
    ld_addr = 32'h304;
    #1;
    check("hazard_next_word", {31'b0, ld_hazard}, 32'd0);
    mem_busy = 1'b0;
    ld_addr  = 32'hFFFF_FFF0;
    @(negedge CLK);
    @(negedge CLK);

    // Asynchronous reset with two stalled stores pending.
    mem_busy = 1'b1;
    send(2'd2, 32'h500, 32'h5555_0000);
    @(negedge CLK);
    send(2'd2, 32'h504, 32'h5555_0004);
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    check("pre_rst_wen", {31'b0, mem_wen}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    check("async_rst_wen", {31'b0, mem_wen}, 32'd0);
    check("async_rst_empty", {31'b0, empty}, 32'd1);
    check("async_rst_ready", {31'b0, st_ready}, 32'd1);
    check("async_rst_addr", mem_addr, 32'h0);
    #1;
    RST = 1'b0;
    mem_busy = 1'b0;
    wen_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1;
      if (mem_wen) wen_seen++;
    end
    check("no_write_after_rst", wen_seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
